// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding initiator for the req/gnt/rvalid peripheral data bus.
// Commands from the local command port are buffered in a small FIFO. Each command is driven
// onto the bus in turn, and exactly one response is returned per command, in command order.
//
// Optional feature: define PERIPH_MASTER_TIMEOUT_EN to add the gnt/rvalid timeout. A timed-out
// transaction completes with rsp_err=1 and rsp_rdata=0. Without the macro the master waits
// indefinitely and rsp_err is tied low.
//
// Ports:
//   HCLK, HRESETn                     clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake (cmd_ready = FIFO not full)
//   cmd_write, cmd_addr, cmd_wdata    command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                response payload
//   data_req, data_we, data_addr,     registered bus request outputs
//   data_wdata
//   data_gnt, data_rvalid, data_rdata responder inputs
//   busy                              FSM not idle or FIFO not empty
module periph_bus_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  data_req,
    output logic                  data_we,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_gnt,
    input  logic                  data_rvalid,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] WAIT_RV = 2'd2;
    localparam logic [1:0] RSP     = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_write;
    logic [PW-2:0]         wr_idx, rd_idx;
    logic                  empty, full, idle, push, pop, bypass;
    logic                  rv_done, tmo_hit, tmo_fire;

    assign wr_idx    = wr_ptr_q[PW-2:0];
    assign rd_idx    = rd_ptr_q[PW-2:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
    assign cmd_ready = !full;
    assign idle      = (state_q == IDLE);

    // An idle master with an empty FIFO takes the command straight into the transaction
    // register; this is a same-cycle push+pop that leaves the FIFO untouched and lets the
    // request appear the cycle after accept.
    assign bypass = idle && empty && cmd_valid;
    assign push   = cmd_valid && !full && !bypass;
    assign pop    = idle && !empty;

    assign rv_done   = (state_q == WAIT_RV) && data_rvalid;
    assign rsp_valid = (state_q == RSP);
    assign busy      = !idle || !empty;

`ifdef PERIPH_MASTER_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Fires on the last allowed waiting cycle, so data_req is high for exactly TIMEOUT cycles.
    assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (state_q == REQ || state_q == WAIT_RV) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_err <= 1'b0;
        end else if (rv_done) begin
            rsp_err <= 1'b0;
        end else if (tmo_fire) begin
            rsp_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign tmo_fire = tmo_hit && (((state_q == REQ) && !data_gnt) ||
                                  ((state_q == WAIT_RV) && !data_rvalid));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop || bypass) state_d = REQ;
            REQ:     if (data_gnt) state_d = WAIT_RV;
                     else if (tmo_fire) state_d = RSP;
            WAIT_RV: if (data_rvalid || tmo_fire) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_addr[wr_idx]  <= cmd_addr;
            fifo_wdata[wr_idx] <= cmd_wdata;
            fifo_write[wr_idx] <= cmd_write;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_req   <= 1'b0;
            data_we    <= 1'b0;
            data_addr  <= '0;
            data_wdata <= '0;
            rsp_rdata  <= '0;
        end else begin
            state_q  <= state_d;
            data_req <= (state_d == REQ);
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            // The bus outputs double as the transaction register and hold outside REQ.
            if (pop) begin
                data_we    <= fifo_write[rd_idx];
                data_addr  <= fifo_addr[rd_idx];
                data_wdata <= fifo_wdata[rd_idx];
            end else if (bypass) begin
                data_we    <= cmd_write;
                data_addr  <= cmd_addr;
                data_wdata <= cmd_wdata;
            end
            if (rv_done) begin
                rsp_rdata <= data_we ? '0 : data_rdata;
            end else if (tmo_fire) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
module tb_periph_bus_master;

`ifdef PERIPH_MASTER_TIMEOUT_EN
    localparam int unsigned TMO = 10;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, busy;
    logic [31:0] data_addr, data_wdata, data_rdata;

    // Responder model controls
    logic        gnt_en = 1'b1, rv_en = 1'b1, force_rv = 1'b0, rdata_mode = 1'b0;
    logic        rv_pend;
    logic [31:0] rv_addr_q;

    int checks = 0;
    int errors = 0;

    periph_bus_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .TIMEOUT(TMO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    // GPIO-like responder: combinational grant, completion one cycle after grant.
    assign data_gnt    = data_req && gnt_en;
    assign data_rvalid = rv_pend || force_rv;
    assign data_rdata  = rdata_mode ? (rv_addr_q + 32'd1) : 32'h0000_A5A5;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rv_pend   <= 1'b0;
            rv_addr_q <= '0;
        end else begin
            rv_pend <= data_req && data_gnt && rv_en;
            if (data_req && data_gnt) rv_addr_q <= data_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Waits (bounded) until rsp_valid is high.
    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check_eq({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check_eq({tag, "_data_req"}, {31'd0, data_req}, 32'd0);
        check_eq({tag, "_data_we"}, {31'd0, data_we}, 32'd0);
        check_eq({tag, "_data_addr"}, data_addr, 32'd0);
        check_eq({tag, "_data_wdata"}, data_wdata, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Pushes five reads with responses blocked, then drains them in order.
    task automatic burst(input logic [31:0] base);
        logic [31:0] exp;
        rsp_ready  = 1'b0;
        rdata_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_cmd_ready_open", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = base + 32'(4 * i);
            tick();
        end
        cmd_valid = 1'b0;
        check_eq("bp_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("bp_rsp_valid");
            exp = base + 32'(4 * i) + 32'd1;
            check_eq("bp_rsp_order", rsp_rdata, exp);
            check_eq("bp_rsp_err", {31'd0, rsp_err}, 32'd0);
            tick();
        end
        rsp_ready = 1'b0;
        tick();
        check_eq("bp_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int n;
        #3;
        check_reset_outputs("rst");
        tick();
        HRESETn = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        // Best-case read: accept c0, req c1, rvalid c2, rsp c3.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1A10_1000;
        tick();
        cmd_valid = 1'b0;
        check_eq("rd_c1_req", {31'd0, data_req}, 32'd1);
        check_eq("rd_c1_addr", data_addr, 32'h1A10_1000);
        check_eq("rd_c1_we", {31'd0, data_we}, 32'd0);
        tick();
        check_eq("rd_c2_req", {31'd0, data_req}, 32'd0);
        check_eq("rd_c2_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_eq("rd_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("rd_c3_rdata", rsp_rdata, 32'h0000_A5A5);
        check_eq("rd_c3_err", {31'd0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("rd_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rd_c4_busy", {31'd0, busy}, 32'd0);
        check_eq("rd_hold_addr", data_addr, 32'h1A10_1000);

        // Write with grant withheld 5 cycles: req high 6 cycles, payload stable.
        gnt_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1A10_1004; cmd_wdata = 32'h1234;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("wr_stall_req", {31'd0, data_req}, 32'd1);
            check_eq("wr_stall_addr", data_addr, 32'h1A10_1004);
            check_eq("wr_stall_we", {31'd0, data_we}, 32'd1);
            check_eq("wr_stall_wdata", data_wdata, 32'h1234);
            if (i == 5) gnt_en = 1'b1;
            tick();
        end
        check_eq("wr_req_drop", {31'd0, data_req}, 32'd0);
        wait_rsp("wr_rsp_valid");
        check_eq("wr_rdata", rsp_rdata, 32'd0);
        check_eq("wr_err", {31'd0, rsp_err}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("wr_single_rsp", {31'd0, rsp_valid}, 32'd0);

        // Backpressure and pointer wrap: two bursts of five.
        burst(32'h0000_0100);
        burst(32'h0000_0200);

        // Timeout behaviour (or indefinite wait without the feature).
        gnt_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0300;
        tick();
        cmd_valid = 1'b0;
        n = 0;
`ifdef PERIPH_MASTER_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            if (data_req) n++;
            tick();
        end
        check_eq("tmo_req_cycles", n, 32'd10);
        check_eq("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("tmo_err", {31'd0, rsp_err}, 32'd1);
        check_eq("tmo_rdata", rsp_rdata, 32'd0);
        gnt_en = 1'b1;
`else
        for (int i = 0; i < 100; i++) begin
            if (data_req) n++;
            tick();
        end
        check_eq("notmo_req_cycles", n, 32'd100);
        check_eq("notmo_no_rsp", {31'd0, rsp_valid}, 32'd0);
        gnt_en = 1'b1;
        wait_rsp("notmo_rsp_valid");
        check_eq("notmo_rdata", rsp_rdata, 32'h0000_0301);
        check_eq("notmo_err", {31'd0, rsp_err}, 32'd0);
`endif
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();

        // Async reset while waiting for rvalid, with another command queued.
        rv_en = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0400; cmd_wdata = 32'hBEEF;
        tick();
        cmd_addr = 32'h0000_0404;
        tick();
        cmd_valid = 1'b0;
        check_eq("arst_pre_wait_req", {31'd0, data_req}, 32'd0);
        check_eq("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        rv_en = 1'b1;
        tick();
        force_rv = 1'b1;
        tick();
        force_rv = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid || data_req) n++;
            tick();
        end
        check_eq("arst_late_rvalid_ignored", n, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

Single-outstanding initiator for the core-side peripheral data interface (req/gnt/rvalid). It accepts read/write commands from a local command port, buffers them in a small FIFO, and drives each one onto the peripheral bus toward responders such as the GPIO block. It returns exactly one response per command. It serves as a test/DMA-style requester that can exercise or sequence peripherals without the RI5CY core.

## Interface
- DATA_WIDTH, 32, width of bus wdata/rdata and response data
- ADDR_WIDTH, 32, width of bus and command address
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2
- TIMEOUT, 255, max cycles waited for gnt or for rvalid (8-bit counter)

Ports:
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response held
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  transaction timed out
- data_req  out  1  bus request
- data_we  out  1  bus write enable
- data_addr  out  ADDR_WIDTH  bus address
- data_wdata  out  DATA_WIDTH  bus write data
- data_gnt  in  1  responder grant; may be combinational from data_req
- data_rvalid  in  1  responder completion, ≥1 cycle after gnt
- data_rdata  in  DATA_WIDTH  read data, valid with data_rvalid
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- Command FIFO: push on cmd_valid & cmd_ready. cmd_ready = !full; it does not depend on a same-cycle pop. Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. full/empty come from MSB compare.
- FSM states:
  - IDLE: FIFO non-empty → pop head into the transaction register → REQ.
  - REQ: data_req=1, with we/addr/wdata driven from the register and held stable. data_gnt=1 → WAIT_RV.
  - WAIT_RV: data_req=0. data_rvalid=1 → capture data_rdata (reads) or 0 (writes), rsp_err=0 → RSP.
  - RSP: rsp_valid=1. rsp_ready=1 → IDLE.
- Only one transaction is outstanding. No new req is issued while in WAIT_RV or RSP.
- data_rvalid outside WAIT_RV is ignored. data_gnt outside REQ is ignored.
- Every command yields exactly one response, in command order.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, data_req=0, data_we=0, data_addr=0, data_wdata=0, busy=0. FIFO is emptied and FSM goes to IDLE.
- Best-case read, cycle numbers from command accept:
  - c0: command accept
  - c1: data_req=1 with same-cycle gnt
  - c2: data_rvalid=1
  - c3: rsp_valid=1
- If rsp_ready=1 in c3, the next FIFO entry's req appears in c5 (IDLE in c4).
- data_req stays high across any number of gnt=0 cycles.
- Bus outputs are registered. data_addr, data_we and data_wdata keep their last value outside REQ.
- Reset asserted mid-transaction: data_req drops asynchronously and the pending command and response are discarded. A responder's late rvalid after reset release is ignored because the FSM is in IDLE.
- Simultaneous push and pop with FIFO at 1 entry: count unchanged, no data loss.

## Configuration
- PERIPH_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and WAIT_RV and increments each cycle in those states.
  - When it reaches TIMEOUT without gnt or rvalid respectively: data_req deasserts, FSM → RSP with rsp_err=1, rsp_rdata=0.
- Macro undefined: no counter; REQ and WAIT_RV wait indefinitely; rsp_err is tied to 0.

## Test plan
- Read, GPIO-like responder (gnt=req, rvalid 1 cycle later, rdata=0x0000_A5A5): push read addr 0x1A10_1000 → req in c1, rsp_valid in c3 with rsp_rdata=0x0000_A5A5, rsp_err=0.
- Write: push write addr 0x1A10_1004 data 0x1234 → data_we=1, data_wdata=0x1234 held until gnt; response rsp_rdata=0, rsp_err=0.
- Grant stall: responder withholds gnt 5 cycles → data_req high 6 cycles with addr stable, one response.
- Backpressure: push 5 commands with rsp_ready=0 → cmd_ready=0 after 4 buffered plus 1 in flight. Release rsp_ready → 5 responses in order; pointers wrap correctly.
- Timeout (macro on, TIMEOUT=10): responder never grants → data_req drops after 10 cycles, rsp_err=1, rsp_rdata=0. With macro off, req stays high for 100 cycles.
- Async reset mid-WAIT_RV → all outputs at reset values immediately. Late rvalid after release → no response.
